// File: rtl/block_scheduler_pkg.sv
// Shared types and helpers for the grid-launch block scheduler.
package sched_pkg;

  localparam int MAX_PB = 16;

  typedef enum logic [1:0] {
    PB_IDLE,
    PB_ARM,
    PB_GUARD,
    PB_RUN
  } pb_state_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } top_state_t;

  // Index of the lowest set bit, or MAX_PB when no bit is set.
  function automatic int lowest_idx(input logic [MAX_PB-1:0] v);
    lowest_idx = MAX_PB;
    for (int i = MAX_PB - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = i;
    end
  endfunction

endpackage

// File: rtl/block_scheduler_if.sv
// Host launch and processing-block array signals of the block scheduler.
interface block_scheduler_if #(
  parameter int NUM_PB = 4,
  parameter int IDX_W  = 16
);
  logic                    start;
  logic [IDX_W-1:0]        num_blocks;
  logic [NUM_PB-1:0]       pb_finished;
  logic [NUM_PB-1:0]       pb_reset;
  logic [NUM_PB*IDX_W-1:0] pb_block_idx;
  logic                    busy;
  logic                    done;
  logic [IDX_W-1:0]        blocks_done;

  modport master (
    output start, num_blocks, pb_finished,
    input  pb_reset, pb_block_idx, busy, done, blocks_done
  );

  modport slave (
    input  start, num_blocks, pb_finished,
    output pb_reset, pb_block_idx, busy, done, blocks_done
  );
endinterface

// File: rtl/block_scheduler_pb_slot.sv
// One processing-block slot: reset sequencing FSM plus the block index it was given.
module pb_slot
  import sched_pkg::*;
#(
  parameter int IDX_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch,
  input  logic [IDX_W-1:0] idx_in,
  input  logic             finished,
  output logic             pb_reset,
  output logic [IDX_W-1:0] idx_out,
  output logic             is_idle,
  output logic             retire
);

  pb_state_t        state_reg, state_next;
  logic             pb_reset_reg;
  logic [IDX_W-1:0] idx_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= PB_IDLE;
      pb_reset_reg <= 1'b1;
      idx_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      pb_reset_reg <= (state_next == PB_IDLE) || (state_next == PB_ARM);
      if (dispatch && (state_reg == PB_IDLE)) idx_reg <= idx_in;
    end
  end

  // The guard cycle skips finished: the PB may still show the halt of its previous block.
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      PB_IDLE:  if (dispatch) state_next = PB_ARM;
      PB_ARM:   state_next = PB_GUARD;
      PB_GUARD: state_next = PB_RUN;
      PB_RUN: begin
        if (finished) begin
          retire     = 1'b1;
          state_next = PB_IDLE;
        end
      end
      default:  state_next = PB_IDLE;
    endcase
  end

  assign pb_reset = pb_reset_reg;
  assign idx_out  = idx_reg;
  assign is_idle  = (state_reg == PB_IDLE);

endmodule

// File: rtl/block_scheduler.sv
// Dispatches grid block indices over NUM_PB processing blocks and reports launch completion.
module block_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_PB = 4,
  parameter int IDX_W  = 16
) (
  input  logic         clock,
  input  logic         reset,
  block_scheduler_if.slave bus
);

  top_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  count_reg, count_next;
  logic [IDX_W-1:0]  next_idx_reg, next_idx_next;
  logic [IDX_W-1:0]  blocks_done_reg, blocks_done_next;
  logic              done_reg, done_next;

  logic [NUM_PB-1:0] idle_vec;
  logic [NUM_PB-1:0] retire_vec;
  logic [NUM_PB-1:0] dispatch_vec;
  logic [NUM_PB-1:0] pb_reset_vec;
  logic              dispatch_en;
  int                grant_idx;
  logic [4:0]        retire_cnt;
  logic [IDX_W:0]    done_sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      count_reg       <= '0;
      next_idx_reg    <= '0;
      blocks_done_reg <= '0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      next_idx_reg    <= next_idx_next;
      blocks_done_reg <= blocks_done_next;
      done_reg        <= done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    next_idx_next    = next_idx_reg;
    blocks_done_next = blocks_done_reg;
    done_next        = 1'b0;
    dispatch_en      = 1'b0;
    grant_idx        = lowest_idx(MAX_PB'(idle_vec));

    retire_cnt = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      retire_cnt = retire_cnt + 5'(retire_vec[i]);
    end
    done_sum = {1'b0, blocks_done_reg} + (IDX_W + 1)'(retire_cnt);

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          count_next       = bus.num_blocks;
          next_idx_next    = '0;
          blocks_done_next = '0;
          state_next       = S_RUN;
        end
      end
      S_RUN: begin
        // Only slots idle at the start of the cycle are eligible, so a slot
        // retiring now waits one cycle before it can be re-armed.
        dispatch_en = (next_idx_reg < count_reg) && (|idle_vec);
        if (dispatch_en) next_idx_next = next_idx_reg + IDX_W'(1);
        if (done_sum > {1'b0, count_reg}) blocks_done_next = count_reg;
        else                              blocks_done_next = done_sum[IDX_W-1:0];
        if ((next_idx_reg == count_reg) && (&idle_vec)) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    for (int i = 0; i < NUM_PB; i++) begin
      dispatch_vec[i] = dispatch_en && (grant_idx == i);
    end
  end

  for (genvar gi = 0; gi < NUM_PB; gi++) begin : g_slot
    pb_slot #(
      .IDX_W(IDX_W)
    ) u_slot (
      .clock    (clock),
      .reset    (reset),
      .dispatch (dispatch_vec[gi]),
      .idx_in   (next_idx_reg),
      .finished (bus.pb_finished[gi]),
      .pb_reset (pb_reset_vec[gi]),
      .idx_out  (bus.pb_block_idx[gi*IDX_W +: IDX_W]),
      .is_idle  (idle_vec[gi]),
      .retire   (retire_vec[gi])
    );
  end

  assign bus.pb_reset    = pb_reset_vec;
  assign bus.busy        = (state_reg == S_RUN);
  assign bus.done        = done_reg;
  assign bus.blocks_done = blocks_done_reg;

endmodule

// File: tb/tb_block_scheduler.sv
// Scoreboard bench for block_scheduler: expected dispatches are queued at launch and matched on each PB release.
module tb_block_scheduler;

  localparam int NUM_PB = 4;
  localparam int IDX_W  = 16;

  typedef struct {
    int idx;
    int slot;
    int rel;
  } disp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  block_scheduler_if #(.NUM_PB(NUM_PB), .IDX_W(IDX_W)) bus ();

  block_scheduler #(.NUM_PB(NUM_PB), .IDX_W(IDX_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  disp_t             sb[$];
  int                checks   = 0;
  int                errors   = 0;
  int                cyc      = 0;
  int                acc_edge = 0;
  int                done_cnt = 0;
  int                done_rel = 0;
  int                done_bd  = 0;
  int                pb_cnt[NUM_PB];
  bit                model_en = 1'b0;
  logic [NUM_PB-1:0] prev_rst = '1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input int idx, input int slot, input int rel);
    disp_t e;
    e.idx  = idx;
    e.slot = slot;
    e.rel  = rel;
    sb.push_back(e);
  endfunction

  // Advance one cycle: observe at the falling edge, then drive the PB model.
  task automatic step();
    disp_t e;
    @(negedge clock);
    for (int i = 0; i < NUM_PB; i++) begin
      if (prev_rst[i] && !bus.pb_reset[i]) begin
        if (sb.size() == 0) begin
          check("disp_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("disp_idx", bus.pb_block_idx[i*IDX_W +: IDX_W], e.idx);
          check("disp_slot", i, e.slot);
          check("disp_edge", cyc - acc_edge, e.rel);
          $display("dispatch idx %0d slot %0d edge %0d", e.idx, i, cyc - acc_edge);
        end
      end
    end
    prev_rst = bus.pb_reset;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_rel = cyc - acc_edge;
      done_bd  = bus.blocks_done;
    end
    if (model_en) begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (bus.pb_reset[i] !== 1'b0) begin
          pb_cnt[i]          = 0;
          bus.pb_finished[i] = 1'b0;
        end else begin
          pb_cnt[i]++;
          bus.pb_finished[i] = (pb_cnt[i] >= 10 + i);
        end
      end
    end
  endtask

  task automatic launch(input int n);
    bus.start      = 1'b1;
    bus.num_blocks = IDX_W'(n);
    acc_edge       = cyc + 1;
    step();
    bus.start      = 1'b0;
    $display("launch num_blocks %0d", n);
  endtask

  task automatic wait_done(input int exp_rel, input int exp_bd);
    int c0;
    int n;
    c0 = done_cnt;
    n  = 0;
    while (done_cnt == c0 && n < 300) begin
      step();
      n++;
    end
    check("done_seen", done_cnt - c0, 1);
    check("done_edge", done_rel, exp_rel);
    check("done_blocks", done_bd, exp_bd);
    $display("done edge %0d blocks_done %0d", done_rel, done_bd);
    repeat (3) step();
    check("done_once", done_cnt - c0, 1);
    check("idle_busy", bus.busy, 0);
    check("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    bus.start       = 1'b0;
    bus.num_blocks  = '0;
    bus.pb_finished = '0;
    for (int i = 0; i < NUM_PB; i++) pb_cnt[i] = 0;

    repeat (3) step();
    check("rst_pb_reset", bus.pb_reset, 4'hF);
    check("rst_idx", bus.pb_block_idx, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_blocks", bus.blocks_done, 0);
    reset = 1'b0;
    step();

    // Empty grid: completes without touching any PB.
    launch(0);
    check("zero_busy", bus.busy, 1);
    check("zero_pb_reset", bus.pb_reset, 4'hF);
    wait_done(1, 0);

    // Six blocks, PB i runs 10+i cycles.
    model_en = 1'b1;
    push(0, 0, 2); push(1, 1, 3); push(2, 2, 4); push(3, 3, 5);
    push(4, 0, 14); push(5, 1, 16);
    launch(6);
    check("six_busy", bus.busy, 1);
    wait_done(28, 6);
    model_en = 1'b0;
    bus.pb_finished = '0;
    step();

    // Stale finished held through arm and guard.
    bus.pb_finished = 4'b0001;
    push(0, 0, 2);
    launch(1);
    check("hold_rst_e0", bus.pb_reset[0], 1);
    step();
    check("hold_rst_e1", bus.pb_reset[0], 1);
    step();
    check("hold_rst_e2", bus.pb_reset[0], 0);
    step();
    check("hold_rst_e3", bus.pb_reset[0], 0);
    check("hold_bd_e3", bus.blocks_done, 0);
    step();
    check("hold_rst_e4", bus.pb_reset[0], 1);
    check("hold_bd_e4", bus.blocks_done, 1);
    wait_done(5, 1);
    bus.pb_finished = '0;
    step();

    // PB0 and PB2 finish together; a start while busy must be ignored.
    push(0, 0, 2); push(1, 1, 3); push(2, 2, 4); push(3, 3, 5);
    push(4, 0, 11); push(5, 2, 12);
    launch(6);
    repeat (6) step();
    bus.start      = 1'b1;
    bus.num_blocks = IDX_W'(2);
    step();
    bus.start = 1'b0;
    check("ign_busy", bus.busy, 1);
    step();
    bus.pb_finished = 4'b0101;
    step();
    bus.pb_finished = '0;
    check("pair_bd", bus.blocks_done, 2);
    check("pair_rst", bus.pb_reset, 4'b0101);
    step();
    check("pair_rst_e10", bus.pb_reset, 4'b0101);
    check("pair_idx0", bus.pb_block_idx[0 +: IDX_W], 4);
    step();
    step();
    bus.pb_finished = '1;
    wait_done(15, 6);
    bus.pb_finished = '0;
    step();

    // Reset mid-launch with three PBs out of reset.
    model_en = 1'b1;
    push(0, 0, 2); push(1, 1, 3); push(2, 2, 4);
    launch(10);
    repeat (4) step();
    check("abort_pre_rst", bus.pb_reset, 4'b1000);
    c0 = done_cnt;
    reset = 1'b1;
    step();
    check("abort_pb_reset", bus.pb_reset, 4'hF);
    check("abort_busy", bus.busy, 0);
    check("abort_blocks", bus.blocks_done, 0);
    check("abort_done", bus.done, 0);
    reset = 1'b0;
    step();
    check("abort_no_done", done_cnt - c0, 0);
    check("abort_sb", sb.size(), 0);
    sb.delete();
    push(0, 0, 2); push(1, 1, 3);
    launch(2);
    wait_done(15, 2);
    model_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
